// File: rtl/uart_word_if.sv
// Valid/ready word handshake between an upstream source and the UART word transmitter.
interface uart_word_if #(
  parameter int DATA_SIZE = 16
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_SIZE-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/uart_word_tx.sv
// Serialises DATA_SIZE-bit words onto an 8N1 UART line, MSB byte first.
module uart_word_tx #(
  parameter int DATA_SIZE    = 16,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_word_if.slave in_if,
  output logic       tx,
  output logic       busy
);
  localparam int NB  = DATA_SIZE / 8;
  localparam int BW  = $clog2(CLKS_PER_BIT);
  localparam int BYW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [BYW-1:0] BYTE_MAX = BYW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [BYW-1:0]       byte_q, byte_d;
  logic [DATA_SIZE-1:0] sh_q, sh_d;

  logic [7:0] cur_byte;
  logic [2:0] bit_nxt;
  logic       baud_last;

  // Byte on the wire always sits at the top of the shift register.
  assign cur_byte  = sh_q[DATA_SIZE-1 -: 8];
  assign bit_nxt   = bit_q + 3'd1;
  assign baud_last = (baud_q == BAUD_MAX);

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    unique case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (in_if.in_valid && ready_q) begin
          sh_d    = in_if.in_data;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          tx_d    = cur_byte[bit_q];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_nxt;
            tx_d  = cur_byte[bit_nxt];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (byte_q == BYTE_MAX) begin
            byte_d  = '0;
            tx_d    = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + 1'b1;
            sh_d    = sh_q << 8;
            tx_d    = 1'b0;
            state_d = START;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
    end
  end

  assign in_if.in_ready = ready_q;
  assign tx             = tx_q;
  assign busy           = busy_q;
endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Downstream consumer of the skid buffer: takes DATA_SIZE-bit words over a valid/ready handshake and transmits each one on a UART line as DATA_SIZE/8 bytes, most-significant byte first. Each byte uses 8N1 framing. The block sits between the skid buffer's output port and the board TX pin. It provides the back-pressure that the skid buffer absorbs.

## Interface
- DATA_SIZE, 16, word width; must be a multiple of 8 and at least 8.
- CLKS_PER_BIT, 104, clock cycles per UART bit; must be at least 2.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word valid; may depend combinationally on the upstream's own input.
- in_data  input  DATA_SIZE  upstream word; sampled only on accept.
- in_ready  output  1  registered; block can accept a word this cycle.
- tx  output  1  registered UART line; idle high.
- busy  output  1  high while a word is being transmitted.

## Operation
- One clock domain. Reset is asynchronous and active-low; assertion takes effect immediately.
- Reset values:
  - state = IDLE, tx = 1, in_ready = 0, busy = 0.
  - All counters = 0. Shift register = 0.
- in_ready goes high on the first rising edge after rst_n deasserts.
- in_ready is a register and never depends combinationally on in_valid or in_data. This keeps the skid buffer's combinational valid path free of loops.
- Accept: in_valid & in_ready on a rising edge.
  - Latch in_data into the shift register.
  - Clear in_ready. Set busy. Go to START.
- States:
  - IDLE: tx = 1.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, from the current byte. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles.
    - If bytes remain: select the next lower byte and go to START, with no gap.
    - Otherwise: go to IDLE, set in_ready, clear busy.
- Byte order: byte index DATA_SIZE/8-1 is sent first; byte 0 is sent last.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Bit counter is 3 bits wide and counts 0..7.
  - Byte counter is max(1, $clog2(DATA_SIZE/8)) bits wide.
  - No counter may exceed its terminal value.
- in_data and in_valid are ignored while in_ready = 0. Upstream holds its word, since the skid buffer keeps it at the queue head.
- Reset mid-word:
  - tx returns to 1 and busy to 0 immediately.
  - The partial word is discarded; a truncated frame on the line is acceptable.
  - in_ready behaves as after power-up reset.

## Timing
- Accept at edge E0:
  - tx falls at E0 (registered output, start bit).
  - Each bit occupies exactly CLKS_PER_BIT cycles.
- One byte = 10*CLKS_PER_BIT cycles.
- One word: tx is driven for (DATA_SIZE/8)*10*CLKS_PER_BIT cycles after E0.
- At edge E0 + (DATA_SIZE/8)*10*CLKS_PER_BIT:
  - state = IDLE, in_ready = 1, busy = 0.
- The earliest next accept is at the following edge.
  - Back-to-back word period = (DATA_SIZE/8)*10*CLKS_PER_BIT + 1 cycles.
  - tx stays high during the extra cycle.
- Latency from accept to the first data bit = CLKS_PER_BIT cycles.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 -> tx = 1, in_ready = 0, busy = 0. After release, in_ready = 1 at the next edge.
- Single word, DATA_SIZE = 16, CLKS_PER_BIT = 4, in_data = 0xA55A:
  - tx, one bit per 4 cycles: 0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,1,1,0,1,0,1.
  - in_ready = 1 again exactly 80 cycles after accept.
- Back-to-back: in_valid held high with words 0x0001 then 0xFF00 -> second accept exactly 81 cycles after the first. The second frame starts with bytes 0xFF, 0x00.
- Back-pressure: in_valid pulses for 1 cycle at random times while busy = 1 -> no accept, no change on tx. The word is accepted only when in_valid = 1 with in_ready = 1.
- Reset mid-word: assert rst_n = 0 during data bit 3 of byte 1 -> tx = 1 and busy = 0 without waiting for a clock edge. After release, a new word 0x1234 transmits correctly.
- Parameter sweep: DATA_SIZE = 8 and 32, CLKS_PER_BIT = 2 -> byte counts 1 and 4, MSB byte first. Word time = 20 and 80 cycles.
